// File: rtl/reg_file_if.sv
// Bus bundle for the operand register file: write-back port plus two
// registered read ports.
interface reg_file_if #(
  parameter int WIDTH = 32
);
  logic             rd_en;
  logic [4:0]       rd_addr_a;
  logic [4:0]       rd_addr_b;
  logic [WIDTH-1:0] rd_data_a;
  logic [WIDTH-1:0] rd_data_b;
  logic             rd_valid;
  logic             wr_en;
  logic [4:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;

  modport master (
    output rd_en, rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data,
    input  rd_data_a, rd_data_b, rd_valid
  );

  modport slave (
    input  rd_en, rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data,
    output rd_data_a, rd_data_b, rd_valid
  );
endinterface

// File: rtl/reg_file.sv
// 32-entry register file with hardwired-zero entry 0, write-through
// forwarding and registered A/B operand outputs.
module reg_file #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  reg_file_if.slave   bus
);

  logic [WIDTH-1:0] mem [1:31];
  logic [WIDTH-1:0] value_a;
  logic [WIDTH-1:0] value_b;

  // Entry 0 has no storage; a same-cycle write to the read address wins.
  function automatic logic [WIDTH-1:0] read_value(input logic [4:0] addr);
    if (addr == 5'd0)
      return '0;
    else if (bus.wr_en && (bus.wr_addr == addr))
      return bus.wr_data;
    else
      return mem[addr];
  endfunction

  always_comb begin
    value_a = read_value(bus.rd_addr_a);
    value_b = read_value(bus.rd_addr_b);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < 32; i++)
        mem[i] <= '0;
      bus.rd_data_a <= '0;
      bus.rd_data_b <= '0;
      bus.rd_valid  <= 1'b0;
    end else begin
      if (bus.wr_en && (bus.wr_addr != 5'd0))
        mem[bus.wr_addr] <= bus.wr_data;
      bus.rd_valid <= bus.rd_en;
      if (bus.rd_en) begin
        bus.rd_data_a <= value_a;
        bus.rd_data_b <= value_b;
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file at WIDTH=8.
module tb_reg_file;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  reg_file_if #(.WIDTH(WIDTH)) bus ();

  reg_file #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] sweep_val(input int i);
    return (i == 0) ? '0 : WIDTH'(i * 3 + 1);
  endfunction

  initial begin
    // reset with conflicting write and read requests
    rst = 1'b1;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 8'hAA;
    bus.rd_en = 1'b1; bus.rd_addr_a = 5'd5; bus.rd_addr_b = 5'd5;
    step(); step();
    check("rst_data_a", 32'(bus.rd_data_a), 32'h0);
    check("rst_data_b", 32'(bus.rd_data_b), 32'h0);
    check("rst_valid",  32'(bus.rd_valid),  32'h0);
    rst = 1'b0; bus.wr_en = 1'b0;
    step();
    check("rst_r5_read",  32'(bus.rd_data_a), 32'h0);
    check("rst_r5_valid", 32'(bus.rd_valid),  32'h1);

    // basic write then read
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 8'h55; step();
    bus.wr_addr = 5'd7; bus.wr_data = 8'h10; step();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b1; bus.rd_addr_a = 5'd3; bus.rd_addr_b = 5'd7; step();
    check("basic_a",     32'(bus.rd_data_a), 32'h55);
    check("basic_b",     32'(bus.rd_data_b), 32'h10);
    check("basic_valid", 32'(bus.rd_valid),  32'h1);
    bus.rd_en = 1'b0; step();
    check("hold_valid", 32'(bus.rd_valid),  32'h0);
    check("hold_a",     32'(bus.rd_data_a), 32'h55);
    check("hold_b",     32'(bus.rd_data_b), 32'h10);

    // zero register, including a same-cycle write to r0
    bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 8'hFF;
    bus.rd_en = 1'b1; bus.rd_addr_a = 5'd0; bus.rd_addr_b = 5'd0; step();
    check("r0_fwd_a", 32'(bus.rd_data_a), 32'h0);
    check("r0_fwd_b", 32'(bus.rd_data_b), 32'h0);
    bus.wr_en = 1'b0; step();
    check("r0_a", 32'(bus.rd_data_a), 32'h0);
    check("r0_b", 32'(bus.rd_data_b), 32'h0);

    // forwarding
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd4; bus.wr_data = 8'h70; step();
    bus.wr_data = 8'h60;
    bus.rd_en = 1'b1; bus.rd_addr_a = 5'd4; bus.rd_addr_b = 5'd4; step();
    check("fwd_a", 32'(bus.rd_data_a), 32'h60);
    check("fwd_b", 32'(bus.rd_data_b), 32'h60);
    bus.wr_en = 1'b0; bus.rd_addr_b = 5'd3; step();
    check("fwd_later_a", 32'(bus.rd_data_a), 32'h60);
    check("fwd_later_b", 32'(bus.rd_data_b), 32'h55);

    // reset mid-operation
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd2; bus.wr_data = 8'h33; step();
    bus.wr_en = 1'b0;
    rst = 1'b1; bus.rd_en = 1'b1; bus.rd_addr_a = 5'd2; bus.rd_addr_b = 5'd2; step();
    check("midrst_a",     32'(bus.rd_data_a), 32'h0);
    check("midrst_valid", 32'(bus.rd_valid),  32'h0);
    rst = 1'b0; step();
    check("post_rst_r2",    32'(bus.rd_data_a), 32'h0);
    check("post_rst_valid", 32'(bus.rd_valid),  32'h1);

    // sweep fill, then back-to-back pair reads
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b1;
    for (int i = 1; i < 32; i++) begin
      bus.wr_addr = 5'(i);
      bus.wr_data = sweep_val(i);
      step();
    end
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus.rd_addr_a = 5'(i);
      bus.rd_addr_b = 5'(31 - i);
      step();
      check($sformatf("sweep_a[%0d]", i),     32'(bus.rd_data_a), 32'(sweep_val(i)));
      check($sformatf("sweep_b[%0d]", i),     32'(bus.rd_data_b), 32'(sweep_val(31 - i)));
      check($sformatf("sweep_valid[%0d]", i), 32'(bus.rd_valid),  32'h1);
    end
    bus.rd_en = 1'b0; step();
    check("sweep_end_valid", 32'(bus.rd_valid),  32'h0);
    check("sweep_end_hold",  32'(bus.rd_data_a), 32'(sweep_val(31)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_file.md
# reg_file

Multicycle-datapath register file: 32 entries of WIDTH bits, one synchronous write port and two read ports whose results are captured into registered outputs (the A/B operand registers). It sits between instruction decode and the ALU. Register-transfer logic writes results back through the write port. Operand fetch reads through the read ports, one clock after a read is requested. Entry 0 is hardwired to zero, and a same-cycle write to a register being read is forwarded.

## Interface
- WIDTH, 32, data width of every entry and every data port
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- rd_en  input  1  capture new read results into rd_data_a/rd_data_b this edge
- rd_addr_a  input  5  read port A address
- rd_addr_b  input  5  read port B address
- rd_data_a  output  WIDTH  registered read result A
- rd_data_b  output  WIDTH  registered read result B
- rd_valid  output  1  rd_data_a/b updated on the previous edge (single-cycle pulse per rd_en)
- wr_en  input  1  write enable
- wr_addr  input  5  write address
- wr_data  input  WIDTH  write data

## Operation
- Storage: entries 1..31 are WIDTH-bit registers. Entry 0 has no storage and always reads 0.
- Write: on an edge with wr_en=1 and wr_addr!=0, entry[wr_addr] <= wr_data. A write with wr_addr=0 is ignored without error.
- Read: on an edge with rd_en=1:
  - rd_data_a <= value(rd_addr_a)
  - rd_data_b <= value(rd_addr_b)
  - rd_valid <= 1
- On an edge with rd_en=0: rd_data_a/b hold their previous values and rd_valid <= 0.
- value(addr):
  - 0 if addr=0;
  - otherwise wr_data if wr_en=1 and wr_addr=addr in the same cycle (write-through forwarding);
  - otherwise entry[addr].
- Both ports may address the same entry. Both then receive the same value, including the forwarded value.
- Reset (rst=1 at an edge):
  - all entries 1..31 <= 0
  - rd_data_a <= 0, rd_data_b <= 0, rd_valid <= 0
  - rst has priority over wr_en and rd_en in the same cycle, so neither the write nor the capture occurs.
- No state machine is needed beyond the storage array and the rd_valid flag. Reads and writes are independent and may occur in every cycle.

## Timing
- Reset values: every output is 0, and every entry reads 0 after reset.
- Write latency: data is visible to the read path from the edge on which it is written. A read requested in that same cycle returns the new value through forwarding.
- Read latency: 1 cycle. Address and rd_en are sampled at edge N; data and rd_valid appear after edge N and are stable for all of cycle N+1.
- Back-to-back reads are allowed. With rd_en held high, rd_valid stays high and data updates every cycle.
- Reset mid-stream: a rd_en asserted together with rst is lost, and rd_valid stays 0 on the following cycle. After rst deasserts, normal operation resumes on the next edge.
- No combinational path from any input to any output. All outputs are driven by flops.

## Test plan
- Reset: hold rst=1 for 2 edges with wr_en=1, wr_addr=5, wr_data=8'hAA, rd_en=1 -> rd_data_a=rd_data_b=0 and rd_valid=0. Then read addr 5 -> 0.
- Basic write/read (WIDTH=8):
  - write 8'h55 to r3, then 8'h10 to r7;
  - next cycle rd_en=1, rd_addr_a=3, rd_addr_b=7 -> after one edge rd_data_a=8'h55, rd_data_b=8'h10, rd_valid=1;
  - following cycle with rd_en=0 -> rd_valid=0 and data held.
- Zero register: write 8'hFF to r0, then read r0 on both ports -> 8'h00.
- Forwarding:
  - r4 holds 8'h70; in one cycle wr_en=1, wr_addr=4, wr_data=8'h60 with rd_en=1, rd_addr_a=4 -> rd_data_a=8'h60;
  - a later read of r4 -> 8'h60.
- Reset mid-operation:
  - load r2=8'h33; assert rst together with rd_en=1, rd_addr_a=2 -> next cycle rd_data_a=0, rd_valid=0;
  - deassert rst and read r2 -> 8'h00.
- Sweep: write entry i = i*3+1 for i=1..31 on consecutive cycles. Then read pairs (i, 31-i) back-to-back with rd_en held high -> every cycle matches the expected values, with rd_valid continuously 1.
